// File: rtl/nios2_led_pio.sv
// Avalon-MM output PIO for the board LEDs: data register with set/clear aliases
// plus a per-bit blink engine driven by a programmable prescaler.
module nios2_led_pio #(
   parameter int unsigned DATA_WIDTH   = 10,
   parameter int unsigned PERIOD_WIDTH = 24,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   mask_q, mask_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    phase_q, phase_d;
   logic [31:0]             readdata_q, readdata_d;
   logic [DATA_WIDTH-1:0]   out_port_q, out_port_d;

   logic                    wr_c;
   logic [PERIOD_WIDTH-1:0] wd_period_c;
   logic                    unused_wd_c;

   assign wr_c        = chipselect & ~write_n;
   assign wd_period_c = writedata[PERIOD_WIDTH-1:0];
   assign unused_wd_c = ^writedata[31:PERIOD_WIDTH];

   // Prescaler, register writes and output/read-data next-state
   always_comb begin
      data_d     = data_q;
      mask_d     = mask_q;
      period_d   = period_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      readdata_d = 32'd0;
      out_port_d = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});

      if (period_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d   = period_q;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q - PERIOD_WIDTH'(1);
      end

      if (wr_c) begin
         case (address)
            ADDR_DATA:     data_d = writedata[DATA_WIDTH-1:0];
            ADDR_MASK:     mask_d = writedata[DATA_WIDTH-1:0];
            ADDR_PERIOD: begin
               // Reload restarts the count from the new value; phase is kept
               period_d = wd_period_c;
               cnt_d    = wd_period_c;
               phase_d  = (wd_period_c == '0) ? 1'b0 : phase_q;
            end
            ADDR_OUTSET:   data_d = data_q | writedata[DATA_WIDTH-1:0];
            ADDR_OUTCLEAR: data_d = data_q & ~writedata[DATA_WIDTH-1:0];
            default:       ;
         endcase
      end

      case (address)
         ADDR_DATA:   readdata_d = 32'(data_q);
         ADDR_MASK:   readdata_d = 32'(mask_q);
         ADDR_PERIOD: readdata_d = 32'(period_q);
         ADDR_STATUS: readdata_d = 32'(phase_q);
         default:     readdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         mask_q     <= '0;
         period_q   <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         readdata_q <= 32'd0;
         out_port_q <= RESET_VALUE;
      end else begin
         data_q     <= data_d;
         mask_q     <= mask_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
         out_port_q <= out_port_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = out_port_q;

endmodule

// File: tb/tb_nios2_led_pio.sv
// Bench for nios2_led_pio: directed register/blink scenarios followed by random
// bus traffic, all checked against a time-based reference model.
module tb_nios2_led_pio;

   localparam logic [9:0] RV = 10'h155;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  out_port;

   int vectors;
   int miscompares;

   // Model: blink phase is derived from the edge count since the last period load
   logic [9:0]  m_data, m_mask;
   logic [23:0] m_period;
   longint      m_cyc, m_load_cyc;
   logic        m_load_phase;

   nios2_led_pio #(.DATA_WIDTH(10), .PERIOD_WIDTH(24), .RESET_VALUE(RV)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic phase_at(input longint c);
      longint n;
      if (m_period == 24'd0) return 1'b0;
      n = (c - m_load_cyc) / (longint'(m_period) + 1);
      return m_load_phase ^ n[0];
   endfunction

   task automatic model_reset();
      m_data = RV; m_mask = '0; m_period = '0;
      m_cyc = 0; m_load_cyc = 0; m_load_phase = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wd);
      logic [9:0]  pd, pm, exp_out;
      logic [23:0] pp;
      logic        pph;
      logic [31:0] exp_rd;
      chipselect = cs; write_n = wn; address = a; writedata = wd;
      @(posedge clk);
      pd = m_data; pm = m_mask; pp = m_period; pph = phase_at(m_cyc);
      if (cs && !wn) begin
         case (a)
            3'd0: m_data = wd[9:0];
            3'd1: m_mask = wd[9:0];
            3'd2: begin
               m_period     = wd[23:0];
               m_load_cyc   = m_cyc + 1;
               m_load_phase = (wd[23:0] == 24'd0) ? 1'b0 : pph;
            end
            3'd4: m_data = m_data | wd[9:0];
            3'd5: m_data = m_data & ~wd[9:0];
            default: ;
         endcase
      end
      m_cyc++;
      exp_out = pd ^ (pm & {10{pph}});
      case (a)
         3'd0:    exp_rd = {22'd0, pd};
         3'd1:    exp_rd = {22'd0, pm};
         3'd2:    exp_rd = {8'd0, pp};
         3'd3:    exp_rd = {31'd0, pph};
         default: exp_rd = 32'd0;
      endcase
      #1;
      check({tag, ".out_port"}, {22'd0, out_port}, {22'd0, exp_out});
      check({tag, ".readdata"}, readdata, exp_rd);
   endtask

   task automatic idle(input string tag, input int n, input logic [2:0] a);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, a, 32'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
      model_reset();
      #12;
      check("reset.out_port", {22'd0, out_port}, {22'd0, RV});
      check("reset.readdata", readdata, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      idle("reset.status", 2, 3'd3);

      // Upper write-data bits dropped; LED follows two edges after the write
      step("wr_data", 1'b1, 1'b0, 3'd0, 32'hFFFF_F0A5);
      idle("rd_data", 3, 3'd0);

      // Set/clear aliases and their zero read-back
      step("wr_f0", 1'b1, 1'b0, 3'd0, 32'h0F0);
      step("outset", 1'b1, 1'b0, 3'd4, 32'h00F);
      idle("rd_set", 2, 3'd4);
      idle("rd_data_ff", 2, 3'd0);
      step("outclr", 1'b1, 1'b0, 3'd5, 32'h0F0);
      idle("rd_clr", 2, 3'd5);
      idle("rd_data_0f", 2, 3'd0);
      idle("rd_67", 1, 3'd6);
      step("wr_7", 1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF);
      idle("rd_7", 2, 3'd7);

      // Blink bits[1:0] with period 4
      step("blink_d", 1'b1, 1'b0, 3'd0, 32'd0);
      step("blink_m", 1'b1, 1'b0, 3'd1, 32'h003);
      step("blink_p", 1'b1, 1'b0, 3'd2, 32'd4);
      idle("blink_run", 25, 3'd3);
      step("period0", 1'b1, 1'b0, 3'd2, 32'd0);
      idle("blink_off", 12, 3'd3);

      // Clearing a mask bit mid-blink returns that LED to its data value
      step("blink_p2", 1'b1, 1'b0, 3'd2, 32'd2);
      idle("blink2", 4, 3'd3);
      step("mask_clr", 1'b1, 1'b0, 3'd1, 32'h001);
      idle("mask_run", 8, 3'd1);

      // Asynchronous reset while phase is high
      step("blink_m3", 1'b1, 1'b0, 3'd1, 32'h003);
      step("blink_p3", 1'b1, 1'b0, 3'd2, 32'd3);
      for (int i = 0; i < 20 && phase_at(m_cyc) == 1'b0; i++) idle("wait_phase", 1, 3'd3);
      check("phase_high", {31'd0, phase_at(m_cyc)}, 32'd1);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_rst.out_port", {22'd0, out_port}, {22'd0, RV});
      check("async_rst.readdata", readdata, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      idle("post_rst", 12, 3'd3);

      // Random bus traffic; small period values so the blink engine keeps toggling
      for (int i = 0; i < 400; i++) begin
         logic [2:0]  a;
         logic [31:0] wd;
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (a == 3'd2) wd = ($urandom_range(0, 7) == 0) ? 32'd0 : {$urandom_range(0, 255), 24'(($urandom_range(1, 6)))};
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
